mpss_bus_arb: RTL and testbench

Shares one MPSS slave bus port (GPIO-class peripheral: req/we/addr/be/wdata in, ack/resp/rdata out) between NMASTERS requesters (cores, debug master).
- Arbitrates each cycle and forwards the winner's request combinationally.
- Tracks outstanding reads in an ID FIFO so each read response is routed back to its issuer.
- Sits between the interconnect master ports and a single peripheral.

---
 rtl/mpss_bus_arb_pkg.sv | 19 +
 rtl/mpss_bus_arb_if.sv | 28 ++
 rtl/mpss_bus_arb_rdq.sv | 61 ++++++
 rtl/mpss_bus_arb.sv | 127 ++++++++++++
 tb/tb_mpss_bus_arb.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mpss_bus_arb_pkg.sv
// Shared widths and helpers for the mpss_bus_arb bus arbiter slice.
// Bus fields are fixed at 32-bit address/data with 4 byte enables.
package mpss_bus_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mpss_bus_arb_if.sv
// MPSS slave-port bundle, N ports wide with lane i at [W*i +: W].
// master drives requests and receives ack/resp/rdata; slave is the reverse.
interface mpss_bus_arb_if
  import mpss_bus_arb_pkg::*;
#(
  parameter int N = 1
);

  logic [N-1:0]        req;
  logic [N-1:0]        we;
  logic [ADDR_W*N-1:0] addr;
  logic [BE_W*N-1:0]   be;
  logic [DATA_W*N-1:0] wdata;
  logic [N-1:0]        ack;
  logic [N-1:0]        resp;
  logic [DATA_W*N-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, resp, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, resp, rdata
  );

endinterface

// File: rtl/mpss_bus_arb_rdq.sv
// Read-ID FIFO: remembers which master issued each outstanding read.
// Head is read combinationally so a response can be routed in its own cycle.
module mpss_bus_arb_rdq
  import mpss_bus_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head_id,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign empty   = (r_count == '0);
  assign full    = (r_count == (PTR_W+1)'(DEPTH));
  assign head_id = r_mem[r_rd_ptr];
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mpss_bus_arb.sv
// NMASTERS-to-1 MPSS slave-port arbiter with read-response routing.
// Define MPSS_BUS_ARB_RR_EN for round-robin; otherwise lowest index wins.
module mpss_bus_arb
  import mpss_bus_arb_pkg::*;
#(
  parameter int NMASTERS  = 4,
  parameter int RDQ_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mpss_bus_arb_if.slave        m_bus,
  mpss_bus_arb_if.master       s_bus,
  output logic                 err_o
);

  localparam int ID_W = (clog2(NMASTERS) < 1) ? 1 : clog2(NMASTERS);

  logic [NMASTERS-1:0] w_elig;
  logic [NMASTERS-1:0] w_elig_rot;
  logic [ID_W-1:0]     w_off;
  logic                w_any;
  logic [ID_W-1:0]     w_grant;
  logic                w_active;
  logic                w_accept;
  logic                w_pop;
  logic                w_rdq_full;
  logic                w_rdq_empty;
  logic [ID_W-1:0]     w_head;
  logic                r_err;

  // Writes bypass the read queue, so only reads are held off when it is full.
  assign w_elig = m_bus.req & (m_bus.we | {NMASTERS{~w_rdq_full}});

`ifdef MPSS_BUS_ARB_RR_EN
  logic [ID_W-1:0]       r_rr_ptr;
  logic [2*NMASTERS-1:0] w_elig_dbl;
  logic [ID_W:0]         w_sum;

  assign w_elig_dbl = {w_elig, w_elig} >> r_rr_ptr;
  assign w_elig_rot = w_elig_dbl[NMASTERS-1:0];
  assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_grant    = (w_sum >= (ID_W+1)'(NMASTERS))
                    ? ID_W'(w_sum - (ID_W+1)'(NMASTERS))
                    : w_sum[ID_W-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_grant == ID_W'(NMASTERS - 1)) ? '0 : w_grant + ID_W'(1);
    end
  end
`else
  assign w_elig_rot = w_elig;
  assign w_grant    = w_off;
`endif

  // Offset of the first eligible master in rotated order.
  always_comb begin
    w_off = '0;
    w_any = 1'b0;
    for (int k = NMASTERS - 1; k >= 0; k--) begin
      if (w_elig_rot[k]) begin
        w_off = ID_W'(k);
        w_any = 1'b1;
      end
    end
  end

  assign w_active = w_any && rst_i;
  assign w_accept = w_active && s_bus.ack[0];
  assign w_pop    = rst_i && s_bus.resp[0] && !w_rdq_empty;

  always_comb begin
    s_bus.req   = 1'b0;
    s_bus.we    = 1'b0;
    s_bus.addr  = '0;
    s_bus.be    = '0;
    s_bus.wdata = '0;
    if (w_active) begin
      s_bus.req   = 1'b1;
      s_bus.we    = m_bus.we[w_grant];
      s_bus.addr  = m_bus.addr[w_grant*ADDR_W +: ADDR_W];
      s_bus.be    = m_bus.be[w_grant*BE_W +: BE_W];
      s_bus.wdata = m_bus.wdata[w_grant*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    m_bus.ack  = '0;
    m_bus.resp = '0;
    if (w_accept) begin
      m_bus.ack[w_grant] = 1'b1;
    end
    if (w_pop) begin
      m_bus.resp[w_head] = 1'b1;
    end
  end

  assign m_bus.rdata = {NMASTERS{s_bus.rdata}};

  mpss_bus_arb_rdq #(
    .WIDTH (ID_W),
    .DEPTH (RDQ_DEPTH)
  ) u_rdq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (w_accept && !m_bus.we[w_grant]),
    .push_id (w_grant),
    .pop     (w_pop),
    .head_id (w_head),
    .empty   (w_rdq_empty),
    .full    (w_rdq_full)
  );

  // A response with nothing outstanding latches an error until reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (s_bus.resp[0] && w_rdq_empty) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

endmodule

// File: tb/tb_mpss_bus_arb.sv
// Directed self-checking bench for mpss_bus_arb (4 masters, 4-deep read queue).
// Expected grant orders switch with MPSS_BUS_ARB_RR_EN.
module tb_mpss_bus_arb;

  logic clk_i;
  logic rst_i;
  logic err_o;

  int n_tests;
  int n_fail;
  int exp_fair [5];
  int exp_prio [4];

  mpss_bus_arb_if #(.N(4)) m_bus ();
  mpss_bus_arb_if #(.N(1)) s_bus ();

  mpss_bus_arb #(
    .NMASTERS  (4),
    .RDQ_DEPTH (4)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .m_bus (m_bus),
    .s_bus (s_bus),
    .err_o (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk_i);
    #1;
  endtask

  task set_m(input int i, input logic req, input logic we,
             input logic [31:0] a, input logic [31:0] d);
    m_bus.req[i]           = req;
    m_bus.we[i]            = we;
    m_bus.addr[32*i +: 32] = a;
    m_bus.wdata[32*i +: 32]= d;
    m_bus.be[4*i +: 4]     = 4'hF;
  endtask

  task clear_m;
    m_bus.req   = '0;
    m_bus.we    = '0;
    m_bus.addr  = '0;
    m_bus.wdata = '0;
    m_bus.be    = '0;
  endtask

  task do_reset;
    rst_i = 1'b0;
    tick;
    rst_i = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
`ifdef MPSS_BUS_ARB_RR_EN
    exp_fair = '{0, 1, 2, 3, 0};
    exp_prio = '{1, 3, 1, 3};
`else
    exp_fair = '{0, 0, 0, 0, 0};
    exp_prio = '{1, 1, 1, 1};
`endif
    clear_m;
    s_bus.ack   = 1'b0;
    s_bus.resp  = 1'b0;
    s_bus.rdata = '0;

    // Reset with live traffic: everything forced quiet.
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 1'b0, 32'h100*i + 32'h10, 32'h0);
    s_bus.ack  = 1'b1;
    s_bus.resp = 1'b1;
    #3;
    chk("rst_s_req", s_bus.req, 0);
    chk("rst_m_ack", m_bus.ack, 0);
    chk("rst_m_resp", m_bus.resp, 0);
    tick;
    chk("rst_err", err_o, 0);
    tick;
    clear_m;
    s_bus.ack  = 1'b0;
    s_bus.resp = 1'b0;
    rst_i = 1'b1;

    // Single write from master 2.
    set_m(2, 1'b1, 1'b1, 32'h80, 32'hDEADBEEF);
    s_bus.ack = 1'b1;
    #3;
    chk("wr_s_req", s_bus.req, 1);
    chk("wr_s_we", s_bus.we, 1);
    chk("wr_s_addr", s_bus.addr, 32'h80);
    chk("wr_s_wdata", s_bus.wdata, 32'hDEADBEEF);
    chk("wr_s_be", s_bus.be, 4'hF);
    chk("wr_m_ack", m_bus.ack, 4'b0100);
    tick;
    clear_m;
    s_bus.ack = 1'b0;

    // Stray response: queue must still be empty after the write.
    s_bus.resp  = 1'b1;
    s_bus.rdata = 32'hCAFE0001;
    #3;
    chk("stray_m_resp", m_bus.resp, 0);
    tick;
    s_bus.resp = 1'b0;
    chk("stray_err", err_o, 1);
    tick;
    chk("stray_err_held", err_o, 1);
    do_reset;
    chk("err_cleared", err_o, 0);

    // Four-way read contention with a one-cycle-response slave.
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 1'b0, 32'h100*i + 32'h10, 32'h0);
    s_bus.ack   = 1'b1;
    s_bus.rdata = 32'h12345678;
    for (int n = 0; n < 5; n++) begin
      s_bus.resp = (n > 0);
      #3;
      chk($sformatf("fair_ack%0d", n), m_bus.ack, 64'd1 << exp_fair[n]);
      chk($sformatf("fair_addr%0d", n), s_bus.addr, 32'h100*exp_fair[n] + 32'h10);
      if (n > 0) begin
        chk($sformatf("fair_resp%0d", n), m_bus.resp, 64'd1 << exp_fair[n-1]);
        chk($sformatf("fair_rdata%0d", n), m_bus.rdata[32*exp_fair[n-1] +: 32], 32'h12345678);
      end
      tick;
    end
    clear_m;
    s_bus.ack  = 1'b0;
    s_bus.resp = 1'b1;
    #3;
    chk("fair_resp_last", m_bus.resp, 64'd1 << exp_fair[4]);
    tick;
    s_bus.resp = 1'b0;
    chk("fair_err", err_o, 0);

    // Masters 1 and 3 contend with writes.
    set_m(1, 1'b1, 1'b1, 32'h110, 32'h11);
    set_m(3, 1'b1, 1'b1, 32'h310, 32'h33);
    s_bus.ack = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #3;
      chk($sformatf("prio_ack%0d", n), m_bus.ack, 64'd1 << exp_prio[n]);
      tick;
    end
    clear_m;
    s_bus.ack = 1'b0;

    // Fill the read queue, then check blocking and release.
    do_reset;
    set_m(1, 1'b1, 1'b0, 32'h110, 32'h0);
    s_bus.ack = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #3;
      chk($sformatf("fill_ack%0d", n), m_bus.ack, 4'b0010);
      tick;
    end
    #3;
    chk("full_s_req", s_bus.req, 0);
    chk("full_m_ack", m_bus.ack, 0);
    tick;
    set_m(0, 1'b1, 1'b1, 32'h40, 32'h5A5A5A5A);
    #3;
    chk("full_wr_ack", m_bus.ack, 4'b0001);
    chk("full_wr_addr", s_bus.addr, 32'h40);
    tick;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_bus.resp = 1'b1;
    #3;
    chk("full_pop_s_req", s_bus.req, 0);
    chk("full_pop_resp", m_bus.resp, 4'b0010);
    tick;
    s_bus.resp = 1'b0;
    #3;
    chk("release_ack", m_bus.ack, 4'b0010);
    tick;
    clear_m;
    s_bus.ack  = 1'b0;
    s_bus.resp = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #3;
      chk($sformatf("drain_resp%0d", n), m_bus.resp, 4'b0010);
      tick;
    end
    chk("drain_err", err_o, 0);
    #3;
    chk("over_resp", m_bus.resp, 0);
    tick;
    s_bus.resp = 1'b0;
    chk("over_err", err_o, 1);

    // Reset while a read is outstanding.
    do_reset;
    chk("mid_err0", err_o, 0);
    set_m(2, 1'b1, 1'b0, 32'h210, 32'h0);
    s_bus.ack = 1'b1;
    #3;
    chk("mid_ack", m_bus.ack, 4'b0100);
    tick;
    clear_m;
    s_bus.ack = 1'b0;
    do_reset;
    s_bus.resp = 1'b1;
    #3;
    chk("mid_resp", m_bus.resp, 0);
    tick;
    s_bus.resp = 1'b0;
    chk("mid_err", err_o, 1);
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 1'b0, 32'h100*i + 32'h10, 32'h0);
    s_bus.ack = 1'b1;
    #3;
    chk("mid_win_ack", m_bus.ack, 4'b0001);
    chk("mid_win_addr", s_bus.addr, 32'h10);
    tick;
    clear_m;
    s_bus.ack = 1'b0;
    chk("mid_err_held", err_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
